hex_adder_display: RTL and testbench

Parametrised successor to the single-digit add-and-display exercise. Adds two WIDTH-bit operands, either continuously (a + b) or as a button-stepped accumulator (acc + a), and drives a time-multiplexed multi-digit 7-segment display in hex. Leading-zero blanking is optional, and carry-out is shown on the decimal point. Sits between the board GPIO (switches, button) and the display pins.

---
 rtl/hex_display_pkg.sv | 48 ++++
 rtl/display_scanner.sv | 97 +++++++++
 rtl/hex_adder_display.sv | 89 ++++++++
 tb/tb_hex_adder_display.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared glyph table and nibble-to-segment decoder for the hex display path.
// Segment order is {a,b,c,d,e,f,g}, active-high, bit 6 = segment a.
package hex_display_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b0011111;
  localparam logic [6:0] GLYPH_C     = 7'b1001110;
  localparam logic [6:0] GLYPH_D     = 7'b0111101;
  localparam logic [6:0] GLYPH_E     = 7'b1001111;
  localparam logic [6:0] GLYPH_F     = 7'b1000111;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Decode one hex nibble to its 7-segment glyph.
  function automatic logic [6:0] nibble_to_abcdefg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      4'hF:    seg = GLYPH_F;
      default: seg = GLYPH_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexed hex display scanner: prescaler, digit index, leading-zero
// blanking and registered segment/enable outputs. Segment data and digit
// enable are registered from the same index so they always change together.
module display_scanner
  import hex_display_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = WIDTH / 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [WIDTH-1:0]  i_sum,
  input  logic              i_carry,
  output logic [6:0]        o_abcdefg,
  output logic              o_dp,
  output logic [DIGITS-1:0] o_digit_n
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [IDX_W-1:0]  r_index;
  logic [6:0]        r_abcdefg;
  logic              r_dp;
  logic [DIGITS-1:0] r_digit_n;

  logic [3:0]        w_nibble;
  logic              w_upper_zero;
  logic              w_blank;
  logic [6:0]        w_glyph;
  logic [DIGITS-1:0] w_digit_n;
  logic              w_dp;

  // Hold each digit for REFRESH_DIV cycles, then move to the next one.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_index <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
      if (r_index == IDX_LAST) begin
        r_index <= '0;
      end else begin
        r_index <= r_index + IDX_W'(1);
      end
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Pick the active nibble, decide blanking, and build next display values.
  always_comb begin
    w_nibble     = 4'h0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_nibble     = w_nibble | (i_sum[i*4 +: 4] & {4{r_index == IDX_W'(i)}});
      // Only the active digit and those above it decide leading-zero status.
      w_upper_zero = w_upper_zero &
                     ((IDX_W'(i) < r_index) | (i_sum[i*4 +: 4] == 4'h0));
    end
    w_blank = (BLANK_LZ != 0) && (r_index != '0) && w_upper_zero;
    if (w_blank) begin
      w_glyph = GLYPH_BLANK;
    end else begin
      w_glyph = nibble_to_abcdefg(w_nibble);
    end
    w_digit_n = ~(DIGITS'(1'b1) << r_index);
    if (r_index == IDX_LAST) begin
      w_dp = i_carry;
    end else begin
      w_dp = 1'b0;
    end
  end

  // Output registers: all digits off and segments dark while in reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_abcdefg <= GLYPH_BLANK;
      r_dp      <= 1'b0;
      r_digit_n <= '1;
    end else begin
      r_abcdefg <= w_glyph;
      r_dp      <= w_dp;
      r_digit_n <= w_digit_n;
    end
  end

  assign o_abcdefg = r_abcdefg;
  assign o_dp      = r_dp;
  assign o_digit_n = r_digit_n;

endmodule

// File: rtl/hex_adder_display.sv
// Hex adder with 7-segment readout. Mode 0 adds a+b every cycle; mode 1
// accumulates sum+a once per synchronised button press. Carry-out of the last
// addition is shown on the decimal point of the most significant digit.
module hex_adder_display
  import hex_display_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = WIDTH / 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              mode,
  input  logic              step,
  input  logic              clear,
  output logic [WIDTH-1:0]  sum,
  output logic              carry,
  output logic [6:0]        abcdefg,
  output logic              dp,
  output logic [DIGITS-1:0] digit_n
);

  logic             r_step_meta;
  logic             r_step_sync;
  logic             r_step_prev;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_step_pulse;
  logic [WIDTH:0]   w_add_ab;
  logic [WIDTH:0]   w_add_acc;

  // Two-flop synchroniser on the button, plus one flop for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_step_meta <= 1'b0;
      r_step_sync <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_meta <= step;
      r_step_sync <= r_step_meta;
      r_step_prev <= r_step_sync;
    end
  end

  assign w_step_pulse = r_step_sync & ~r_step_prev;
  assign w_add_ab     = {1'b0, a} + {1'b0, b};
  assign w_add_acc    = {1'b0, r_sum} + {1'b0, a};

  // Result register: clear beats everything, then mode selects the source.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (clear) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (!mode) begin
      {r_carry, r_sum} <= w_add_ab;
    end else if (w_step_pulse) begin
      {r_carry, r_sum} <= w_add_acc;
    end else begin
      r_sum   <= r_sum;
      r_carry <= r_carry;
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

  display_scanner #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_LZ    (BLANK_LZ)
  ) u_scanner (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_sum     (r_sum),
    .i_carry   (r_carry),
    .o_abcdefg (abcdefg),
    .o_dp      (dp),
    .o_digit_n (digit_n)
  );

endmodule

// File: tb/tb_hex_adder_display.sv
// Self-checking bench for hex_adder_display: directed scenarios plus a
// randomized run against a cycle-level arithmetic reference model.
module tb_hex_adder_display;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int RD  = 4;
  localparam int RD16 = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] a, b;
  logic       mode, step, clear;
  logic [7:0] sum;
  logic       carry;
  logic [6:0] abcdefg;
  logic       dp;
  logic [1:0] digit_n;

  logic [15:0] a16, b16;
  logic        tie0 = 1'b0;
  logic [15:0] sum_bl, sum_nb;
  logic        carry_bl, carry_nb, dp_bl, dp_nb;
  logic [6:0]  seg_bl, seg_nb;
  logic [3:0]  dn_bl, dn_nb;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] glyphs [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  always #5 clock = ~clock;

  hex_adder_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b), .mode(mode), .step(step),
    .clear(clear), .sum(sum), .carry(carry), .abcdefg(abcdefg), .dp(dp),
    .digit_n(digit_n));

  hex_adder_display #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(RD16), .BLANK_LZ(1)) dut_bl (
    .clock(clock), .reset_n(reset_n), .a(a16), .b(b16), .mode(tie0), .step(tie0),
    .clear(tie0), .sum(sum_bl), .carry(carry_bl), .abcdefg(seg_bl), .dp(dp_bl),
    .digit_n(dn_bl));

  hex_adder_display #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(RD16), .BLANK_LZ(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .a(a16), .b(b16), .mode(tie0), .step(tie0),
    .clear(tie0), .sum(sum_nb), .carry(carry_nb), .abcdefg(seg_nb), .dp(dp_nb),
    .digit_n(dn_nb));

  // ---------------- reference model (8-bit instance) ----------------
  int         m_sum, m_carry, m_cyc;
  logic [2:0] m_sh;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [1:0] e_dn;

  function automatic int f_glyph(input int s, input int idx);
    int upper;
    upper = s >> (4 * idx);
    if (idx > 0 && upper == 0) return 0;
    return int'(glyphs[upper % 16]);
  endfunction

  function automatic int f_next(input int s, input int c, input bit pulse,
                                input bit clr, input bit md, input int av, input int bv);
    if (clr) return 0;
    if (!md) return av + bv;
    if (pulse) return s + av;
    return s + 256 * c;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_sum <= 0; m_carry <= 0; m_cyc <= 0; m_sh <= 3'b000;
      e_seg <= 7'd0; e_dp <= 1'b0; e_dn <= 2'b11;
    end else begin
      e_dn  <= 2'b11 ^ 2'(32'd1 << ((m_cyc / RD) % D));
      e_seg <= 7'(f_glyph(m_sum, (m_cyc / RD) % D));
      e_dp  <= (((m_cyc / RD) % D) == D - 1) ? m_carry[0] : 1'b0;
      m_sum   <= f_next(m_sum, m_carry, m_sh[1] & ~m_sh[2], clear, mode, int'(a), int'(b)) % 256;
      m_carry <= f_next(m_sum, m_carry, m_sh[1] & ~m_sh[2], clear, mode, int'(a), int'(b)) / 256;
      m_sh  <= {m_sh[1:0], step};
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; a = 8'h00; b = 8'h00; mode = 1'b0; step = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({sum, carry, abcdefg, dp, digit_n} !== {8'h00, 1'b0, 7'b0000000, 1'b0, 2'b11}) begin
      tests_failed++;
      $display("FAIL reset_values: got sum=%h c=%b seg=%b dp=%b dn=%b", sum, carry, abcdefg, dp, digit_n);
    end
    reset_n = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({digit_n, abcdefg} !== {2'b10, 7'b1111110}) begin
      tests_failed++;
      $display("FAIL first_clock: got dn=%b seg=%b expected dn=10 seg=1111110", digit_n, abcdefg);
    end
  endtask

  task automatic test_scan();
    logic [1:0] seq [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    mode = 1'b0; a = 8'h12; b = 8'h00;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      tests_run++;
      if (digit_n !== seq[k]) begin
        tests_failed++;
        $display("FAIL scan_seq[%0d]: got %b expected %b", k, digit_n, seq[k]);
      end
    end
    tests_run++;
    if (sum !== 8'h12) begin
      tests_failed++;
      $display("FAIL pre_reset_sum: got %h expected 12", sum);
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({digit_n, abcdefg, sum, dp} !== {2'b11, 7'b0000000, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL midframe_reset: got dn=%b seg=%b sum=%h dp=%b", digit_n, abcdefg, sum, dp);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mode0();
    mode = 1'b0; a = 8'h3C; b = 8'h05;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({carry, sum} !== {1'b0, 8'h41}) begin
      tests_failed++;
      $display("FAIL add_3C_05: got c=%b sum=%h expected c=0 sum=41", carry, sum);
    end
    for (int k = 0; k < 2 * RD; k++) begin
      @(negedge clock);
      tests_run++;
      if ((digit_n == 2'b10 && abcdefg !== 7'b0110000) ||
          (digit_n == 2'b01 && abcdefg !== 7'b0110011) ||
          (digit_n != 2'b10 && digit_n != 2'b01) || dp !== 1'b0) begin
        tests_failed++;
        $display("FAIL glyph_41: got dn=%b seg=%b dp=%b", digit_n, abcdefg, dp);
      end
    end
    a = 8'hF0; b = 8'h20;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({carry, sum} !== {1'b1, 8'h10}) begin
      tests_failed++;
      $display("FAIL add_F0_20: got c=%b sum=%h expected c=1 sum=10", carry, sum);
    end
    for (int k = 0; k < 2 * RD; k++) begin
      @(negedge clock);
      tests_run++;
      if (dp !== (digit_n == 2'b01) || {digit_n, abcdefg, dp} !== {e_dn, e_seg, e_dp}) begin
        tests_failed++;
        $display("FAIL dp_carry: got dn=%b seg=%b dp=%b expected dn=%b seg=%b dp=%b",
                 digit_n, abcdefg, dp, e_dn, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] expv [3] = '{8'h07, 8'h0E, 8'h15};
    logic [7:0] prev;
    mode = 1'b1; a = 8'h07; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    prev = 8'h00;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (2) begin
        @(negedge clock);
        tests_run++;
        if (sum !== prev) begin
          tests_failed++;
          $display("FAIL acc_early[%0d]: got %h expected %h", p, sum, prev);
        end
      end
      @(negedge clock);
      tests_run++;
      if (sum !== expv[p]) begin
        tests_failed++;
        $display("FAIL acc_land[%0d]: got %h expected %h", p, sum, expv[p]);
      end
      repeat (7) @(negedge clock);
      tests_run++;
      if (sum !== expv[p]) begin
        tests_failed++;
        $display("FAIL acc_held[%0d]: got %h expected %h", p, sum, expv[p]);
      end
      step = 1'b0;
      repeat (4) @(negedge clock);
      prev = expv[p];
    end
    tests_run++;
    if ({carry, sum} !== {1'b0, 8'h15}) begin
      tests_failed++;
      $display("FAIL acc_final: got c=%b sum=%h expected c=0 sum=15", carry, sum);
    end
  endtask

  task automatic test_collision();
    mode = 1'b1; a = 8'h01;
    step = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    tests_run++;
    if ({carry, sum} !== {1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL clear_wins: got c=%b sum=%h expected c=0 sum=00", carry, sum);
    end
    repeat (3) @(negedge clock);
    step = 1'b0;
    repeat (4) @(negedge clock);
    step = 1'b1;
    repeat (3) @(negedge clock);
    step = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({carry, sum} !== {1'b0, 8'h01}) begin
      tests_failed++;
      $display("FAIL after_clear_press: got c=%b sum=%h expected c=0 sum=01", carry, sum);
    end
  endtask

  task automatic test_blank16();
    logic [3:0] seen;
    logic [6:0] exp_bl, exp_nb;
    seen = 4'h0;
    a16 = 16'h0005; b16 = 16'h0000;
    repeat (3) @(negedge clock);
    tests_run++;
    if (sum_bl !== 16'h0005 || sum_nb !== 16'h0005) begin
      tests_failed++;
      $display("FAIL sum16: got %h / %h expected 0005", sum_bl, sum_nb);
    end
    for (int k = 0; k < 4 * RD16; k++) begin
      @(negedge clock);
      exp_bl = (dn_bl == 4'b1110) ? 7'b1011011 : 7'b0000000;
      exp_nb = (dn_nb == 4'b1110) ? 7'b1011011 : 7'b1111110;
      seen = seen | ~dn_bl;
      tests_run++;
      if (seg_bl !== exp_bl || seg_nb !== exp_nb || dn_bl !== dn_nb ||
          $countones(~dn_bl) != 1) begin
        tests_failed++;
        $display("FAIL blank16: got dn=%b seg_bl=%b seg_nb=%b expected %b / %b",
                 dn_bl, seg_bl, seg_nb, exp_bl, exp_nb);
      end
    end
    tests_run++;
    if (seen !== 4'hF) begin
      tests_failed++;
      $display("FAIL blank16_digits_seen: got %b expected 1111", seen);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      tests_run++;
      if ({sum, carry, abcdefg, dp, digit_n} !== {8'(m_sum), m_carry[0], e_seg, e_dp, e_dn}) begin
        tests_failed++;
        $display("FAIL random[%0d]: got sum=%h c=%b seg=%b dp=%b dn=%b expected sum=%h c=%0d seg=%b dp=%b dn=%b",
                 k, sum, carry, abcdefg, dp, digit_n, 8'(m_sum), m_carry, e_seg, e_dp, e_dn);
      end
      if ($urandom_range(0, 2) == 0) a = 8'($urandom);
      if ($urandom_range(0, 2) == 0) b = 8'($urandom);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) step = ~step;
      clear = ($urandom_range(0, 19) == 0);
    end
    clear = 1'b0; step = 1'b0;
  endtask

  initial begin
    a16 = 16'h0000; b16 = 16'h0000;
    test_reset();
    test_scan();
    test_mode0();
    test_accumulate();
    test_collision();
    test_blank16();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
